// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO steering each head entry to one of NUM_UNITS execution units
// over valid/ready, dropping and counting entries whose unit index is unmapped.
module dispatch_queue #(
    parameter int NUM_UNITS     = 8,
    parameter int DEPTH         = 4,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int RS_ID_WIDTH   = 5,
    parameter int UNIT_IDX_W    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [UNIT_IDX_W-1:0]            in_unit,
    input  logic [PAYLOAD_WIDTH-1:0]         in_payload,
    output logic [NUM_UNITS-1:0]             unit_valid,
    input  logic [NUM_UNITS-1:0]             unit_ready,
    output logic [PAYLOAD_WIDTH-1:0]         unit_payload,
    input  logic [NUM_UNITS*RS_ID_WIDTH-1:0] unit_id,
    output logic                             issue_valid,
    output logic [UNIT_IDX_W-1:0]            issue_unit,
    output logic [RS_ID_WIDTH-1:0]           issue_id,
    output logic                             illegal_valid,
    output logic [7:0]                       illegal_count,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [UNIT_IDX_W-1:0]    unit_mem    [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_mem [DEPTH];

    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [OCC_W-1:0]       occ;
    logic [UNIT_IDX_W-1:0]  head_unit;
    logic                   head_legal;
    logic                   not_empty;
    logic                   handshake;
    logic                   drop;
    logic                   enq;
    logic                   deq;
    logic [RS_ID_WIDTH-1:0] sel_id;

    assign head_unit    = unit_mem[rd_ptr];
    assign unit_payload = payload_mem[rd_ptr];
    assign occupancy    = occ;
    assign not_empty    = (occ != '0);
    assign head_legal   = ({1'b0, head_unit} < (UNIT_IDX_W + 1)'(NUM_UNITS));

    // No full-bypass: a full queue refuses input even while it dequeues.
    assign in_ready = (occ != OCC_W'(DEPTH)) && !rst;

    assign enq       = in_valid && in_ready && !flush;
    assign handshake = |(unit_valid & unit_ready);
    assign drop      = not_empty && !flush && !head_legal;
    assign deq       = handshake || drop;

    // unit_valid is a function of queue state and flush only, never of unit_ready.
    always_comb begin
        unit_valid = '0;
        sel_id     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (head_unit == UNIT_IDX_W'(k)) begin
                unit_valid[k] = not_empty && !flush && head_legal;
                sel_id        = unit_id[k*RS_ID_WIDTH +: RS_ID_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            unit_mem[wr_ptr]    <= in_unit;
            payload_mem[wr_ptr] <= in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
            issue_valid   <= 1'b0;
            issue_unit    <= '0;
            issue_id      <= '0;
            illegal_valid <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
            issue_valid   <= 1'b0;
            illegal_valid <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            issue_valid <= handshake;
            if (handshake) begin
                issue_unit <= head_unit;
                issue_id   <= sel_id;
            end
            illegal_valid <= drop;
            if (drop && (illegal_count != 8'hFF)) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed vector table, hand-written corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_dispatch_queue;

    localparam int NUM_UNITS     = 8;
    localparam int DEPTH         = 4;
    localparam int PAYLOAD_WIDTH = 64;
    localparam int RS_ID_WIDTH   = 5;
    localparam int UNIT_IDX_W    = 4;
    localparam int OCC_W         = $clog2(DEPTH) + 1;

    logic                             clk;
    logic                             rst;
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready;
    logic [UNIT_IDX_W-1:0]            in_unit;
    logic [PAYLOAD_WIDTH-1:0]         in_payload;
    logic [NUM_UNITS-1:0]             unit_valid;
    logic [NUM_UNITS-1:0]             unit_ready;
    logic [PAYLOAD_WIDTH-1:0]         unit_payload;
    logic [NUM_UNITS*RS_ID_WIDTH-1:0] unit_id;
    logic                             issue_valid;
    logic [UNIT_IDX_W-1:0]            issue_unit;
    logic [RS_ID_WIDTH-1:0]           issue_id;
    logic                             illegal_valid;
    logic [7:0]                       illegal_count;
    logic [OCC_W-1:0]                 occupancy;

    dispatch_queue #(
        .NUM_UNITS(NUM_UNITS), .DEPTH(DEPTH), .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
        .RS_ID_WIDTH(RS_ID_WIDTH), .UNIT_IDX_W(UNIT_IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_unit(in_unit), .in_payload(in_payload), .unit_valid(unit_valid),
        .unit_ready(unit_ready), .unit_payload(unit_payload), .unit_id(unit_id),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_id(issue_id),
        .illegal_valid(illegal_valid), .illegal_count(illegal_count), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [UNIT_IDX_W-1:0]    unit;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } entry_t;

    typedef struct {
        logic                  in_valid;
        logic [UNIT_IDX_W-1:0] in_unit;
        logic [NUM_UNITS-1:0]  exp_unit_valid;
        logic [OCC_W-1:0]      exp_occ;
        logic                  exp_issue_valid;
        logic [RS_ID_WIDTH-1:0] exp_issue_id;
    } vec_t;

    entry_t mq[$];
    logic                   m_issue_valid;
    logic [UNIT_IDX_W-1:0]  m_issue_unit;
    logic [RS_ID_WIDTH-1:0] m_issue_id;
    logic                   m_ill_valid;
    int                     m_ill_count;

    int compared;
    int mismatched;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RS_ID_WIDTH-1:0] fixedId(input int k);
        return RS_ID_WIDTH'((k * 3 + 2) % 32);
    endfunction

    task automatic setFixedIds();
        for (int k = 0; k < NUM_UNITS; k++) unit_id[k*RS_ID_WIDTH +: RS_ID_WIDTH] = fixedId(k);
    endtask

    function automatic logic [NUM_UNITS-1:0] modelUnitValid();
        logic [NUM_UNITS-1:0] v;
        v = '0;
        if (mq.size() > 0 && !flush && int'(mq[0].unit) < NUM_UNITS) v[mq[0].unit] = 1'b1;
        return v;
    endfunction

    task automatic checkModel();
        checkOutput("in_ready", in_ready, (mq.size() != DEPTH) && !rst);
        checkOutput("unit_valid", unit_valid, modelUnitValid());
        checkOutput("occupancy", occupancy, mq.size());
        checkOutput("issue_valid", issue_valid, m_issue_valid);
        checkOutput("issue_unit", issue_unit, m_issue_unit);
        checkOutput("issue_id", issue_id, m_issue_id);
        checkOutput("illegal_valid", illegal_valid, m_ill_valid);
        checkOutput("illegal_count", illegal_count, m_ill_count);
        if (mq.size() > 0) checkOutput("unit_payload", unit_payload, mq[0].payload);
    endtask

    task automatic modelEdge();
        logic [NUM_UNITS-1:0] uv;
        logic hs, drop, enq;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_issue_valid = 0; m_issue_unit = '0; m_issue_id = '0;
            m_ill_valid = 0; m_ill_count = 0;
        end else if (flush) begin
            mq.delete();
            m_issue_valid = 0; m_ill_valid = 0;
        end else begin
            uv   = modelUnitValid();
            hs   = |(uv & unit_ready);
            drop = mq.size() > 0 && int'(mq[0].unit) >= NUM_UNITS;
            enq  = in_valid && mq.size() != DEPTH;
            m_issue_valid = hs;
            if (hs) begin
                m_issue_unit = mq[0].unit;
                m_issue_id   = unit_id[int'(mq[0].unit)*RS_ID_WIDTH +: RS_ID_WIDTH];
            end
            m_ill_valid = drop;
            if (drop && m_ill_count < 255) m_ill_count++;
            if (hs || drop) void'(mq.pop_front());
            if (enq) begin
                e.unit = in_unit; e.payload = in_payload;
                mq.push_back(e);
            end
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance both at the edge.
    task automatic applyStimulus();
        #3;
        checkModel();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    int   issues_seen;
    int   next_expected;

    initial begin
        compared = 0; mismatched = 0;
        rst = 1; flush = 0; in_valid = 0; in_unit = '0; in_payload = '0;
        unit_ready = '1; setFixedIds();
        modelEdge();
        @(posedge clk); #1;
        checkOutput("reset_occ", occupancy, 0);
        checkOutput("reset_issue_valid", issue_valid, 0);
        checkOutput("reset_illegal_count", illegal_count, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        rst = 0;

        // Units 2, 5, 0 back to back, all units ready.
        vecs[0] = '{1'b1, 4'd2, 8'h00, 3'd0, 1'b0, 5'd0};
        vecs[1] = '{1'b1, 4'd5, 8'h04, 3'd1, 1'b0, 5'd0};
        vecs[2] = '{1'b1, 4'd0, 8'h20, 3'd1, 1'b1, 5'd8};
        vecs[3] = '{1'b0, 4'd0, 8'h01, 3'd1, 1'b1, 5'd17};
        vecs[4] = '{1'b0, 4'd0, 8'h00, 3'd0, 1'b1, 5'd2};
        vecs[5] = '{1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 5'd2};
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].in_valid; in_unit = vecs[i].in_unit;
            in_payload = 64'hA000 + 64'(i);
            #1;
            checkOutput($sformatf("vec%0d_unit_valid", i), unit_valid, vecs[i].exp_unit_valid);
            checkOutput($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
            checkOutput($sformatf("vec%0d_issue_valid", i), issue_valid, vecs[i].exp_issue_valid);
            checkOutput($sformatf("vec%0d_issue_id", i), issue_id, vecs[i].exp_issue_id);
            applyStimulus();
        end

        // Fill to DEPTH with unit 3 stalled, then drain.
        unit_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_unit = 4'd3; in_payload = 64'hB000 + 64'(i);
            applyStimulus();
        end
        in_payload = 64'hBFFF;
        #1;
        checkOutput("full_occ", occupancy, DEPTH);
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus();
        in_valid = 0; unit_ready[3] = 1;
        issues_seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (issue_valid) issues_seen++;
            applyStimulus();
        end
        checkOutput("drain_issues", issues_seen, DEPTH);
        checkOutput("drain_occ", occupancy, 0);

        // Unmapped unit index 12 is dropped, then a legal entry still issues.
        unit_ready = '1;
        in_valid = 1; in_unit = 4'd12; in_payload = 64'hC00C;
        applyStimulus();
        in_valid = 0;
        #1;
        checkOutput("illegal_no_valid", unit_valid, 0);
        applyStimulus();
        #1;
        checkOutput("illegal_pulse", illegal_valid, 1);
        checkOutput("illegal_count_1", illegal_count, 1);
        in_valid = 1; in_unit = 4'd4; in_payload = 64'hC004;
        applyStimulus();
        in_valid = 0;
        #1;
        checkOutput("legal_after_illegal_valid", unit_valid, 8'h10);
        applyStimulus();
        #1;
        checkOutput("legal_after_illegal_issue", issue_unit, 4);
        applyStimulus();

        // Flush with three entries waiting and a concurrent input offer.
        unit_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_unit = 4'd1; in_payload = 64'hD000 + 64'(i);
            applyStimulus();
        end
        in_valid = 0;
        #1;
        checkOutput("preflush_valid", unit_valid, 8'h02);
        applyStimulus();
        flush = 1; in_valid = 1; in_unit = 4'd6; in_payload = 64'hDEAD;
        #1;
        checkOutput("flush_valid_low", unit_valid, 0);
        applyStimulus();
        flush = 0; in_valid = 0;
        #1;
        checkOutput("flush_occ", occupancy, 0);
        checkOutput("flush_count_kept", illegal_count, 1);
        applyStimulus();

        // Ten entries streamed through; pointers wrap twice, order preserved.
        unit_ready = '1;
        next_expected = 0;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 10); in_unit = UNIT_IDX_W'(i % 8); in_payload = 64'hE000 + 64'(i);
            #1;
            checkOutput("stream_occ_le1", occupancy <= 1, 1);
            if (issue_valid) begin
                checkOutput("stream_order", issue_unit, next_expected % 8);
                next_expected++;
            end
            applyStimulus();
        end
        checkOutput("stream_count", next_expected, 10);

        // Reset mid-stream with two entries queued.
        unit_ready = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_unit = 4'd1; in_payload = 64'hF000 + 64'(i);
            applyStimulus();
        end
        rst = 1; in_valid = 0;
        applyStimulus();
        rst = 0;
        #1;
        checkOutput("rst_occ", occupancy, 0);
        checkOutput("rst_issue_valid", issue_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        applyStimulus();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 24) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_unit = ($urandom_range(0, 9) == 0) ? UNIT_IDX_W'($urandom_range(8, 15))
                                                  : UNIT_IDX_W'($urandom_range(0, 7));
            in_payload = {$urandom, $urandom};
            unit_ready = NUM_UNITS'($urandom) | NUM_UNITS'($urandom);
            for (int k = 0; k < NUM_UNITS; k++)
                unit_id[k*RS_ID_WIDTH +: RS_ID_WIDTH] = RS_ID_WIDTH'($urandom);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
